// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/opcode request side and result side.
// The design takes the slave view; the issuing stage and the consumer take the master view.
interface alu_seq_if #(
  parameter int unsigned M = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic [3:0]   ALU_Sel;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] ALU_Out;
  logic [3:0]   Alu_Flags;
  logic         busy;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, Alu_Flags, busy
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, Alu_Flags, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle logic/add/shift ops, iterative shift-add
// multiply and restoring divide, one operation in flight, valid/ready on both sides.
module alu_seq #(
  parameter int unsigned M = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int unsigned SW = $clog2(M);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  logic [1:0]    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [M-1:0]  b_q, b_d;
  logic [M-1:0]  hi_q, hi_d;
  logic [M-1:0]  lo_q, lo_d;
  logic [M-1:0]  res_q, res_d;
  logic [3:0]    flags_q, flags_d;
  logic [SW-1:0] cnt_q, cnt_d;

  logic [M:0]    add_w, sub_w, shl_w, shr_w;
  logic [SW-1:0] sh;
  logic [M-1:0]  s_res;
  logic          s_c, s_v, s_legal;
  logic [3:0]    s_flags;

  logic [M:0]    mul_sum, div_sh;
  logic [M-1:0]  div_diff, it_hi, it_lo, fin_res;
  logic          div_ge;
  logic [3:0]    fin_flags;

  always_comb begin
    add_w   = {1'b0, bus.A} + {1'b0, bus.B};
    sub_w   = {1'b0, bus.A} - {1'b0, bus.B};
    sh      = bus.B[SW-1:0];
    shl_w   = {1'b0, bus.A} << sh;
    shr_w   = {bus.A, 1'b0} >> sh;
    s_res   = '0;
    s_c     = 1'b0;
    s_v     = 1'b0;
    s_legal = 1'b1;
    case (bus.ALU_Sel)
      OP_ADD: begin
        s_res = add_w[M-1:0];
        s_c   = add_w[M];
        s_v   = (bus.A[M-1] == bus.B[M-1]) && (s_res[M-1] != bus.A[M-1]);
      end
      OP_SUB: begin
        s_res = sub_w[M-1:0];
        s_c   = sub_w[M];
        s_v   = (bus.A[M-1] != bus.B[M-1]) && (s_res[M-1] != bus.A[M-1]);
      end
      OP_AND: s_res = bus.A & bus.B;
      OP_OR:  s_res = bus.A | bus.B;
      OP_XOR: s_res = bus.A ^ bus.B;
      // Widened by one bit so the last bit shifted out lands in a fixed slot (0 for amount 0).
      OP_SHL: begin
        s_res = shl_w[M-1:0];
        s_c   = shl_w[M];
      end
      OP_SHR: begin
        s_res = shr_w[M:1];
        s_c   = shr_w[0];
      end
      OP_MUL, OP_DIV, OP_MOD: s_res = '0;
      default: s_legal = 1'b0;
    endcase
    s_flags = s_legal ? {s_res[M-1], s_res == '0, s_c, s_v} : 4'b0101;
  end

  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, b_q};
    div_sh   = {hi_q, lo_q[M-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    // When the trial subtract succeeds the true difference is below B, so M bits suffice.
    div_diff = div_sh[M-1:0] - b_q;
    if (op_q == OP_MUL) begin
      if (lo_q[0]) begin
        it_hi = mul_sum[M:1];
        it_lo = {mul_sum[0], lo_q[M-1:1]};
      end else begin
        it_hi = {1'b0, hi_q[M-1:1]};
        it_lo = {hi_q[0], lo_q[M-1:1]};
      end
    end else begin
      it_hi = div_ge ? div_diff : div_sh[M-1:0];
      it_lo = {lo_q[M-2:0], div_ge};
    end
    fin_res = (op_q == OP_MOD) ? it_hi : it_lo;
    if (op_q == OP_MUL) begin
      fin_flags = {fin_res[M-1], fin_res == '0, it_hi != '0, it_hi != '0};
    end else begin
      fin_flags = {fin_res[M-1], fin_res == '0, 1'b0, b_q == '0};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d  = bus.ALU_Sel;
          b_d   = bus.B;
          cnt_d = '0;
          if (bus.ALU_Sel == OP_MUL || bus.ALU_Sel == OP_DIV || bus.ALU_Sel == OP_MOD) begin
            hi_d    = '0;
            lo_d    = bus.A;
            state_d = S_EXEC;
          end else begin
            res_d   = s_res;
            flags_d = s_flags;
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(M - 1)) begin
          res_d   = fin_res;
          flags_d = fin_flags;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ALU_Out   = res_q;
  assign bus.Alu_Flags = flags_q;
endmodule
